ctl_sync_initiator: RTL

- Bus-side initiator of the control-BRAM synchronisation handshake. It drives the CPU port of the control BRAM, and the FPGA-side controller is the responder.
- On START it writes the 64-bit EtherCAT sync time as four 16-bit words, writes the per-transducer CYCLE table, sets the SYNC bit in the control register by read-modify-write, and polls until the controller clears that bit.
- Used in the host-bridge path and as the CPU model in system benches.
- Runs in the bus clock domain, which is its only clock.

---
 rtl/ctl_sync_initiator_pkg.sv | 38 +++
 rtl/ctl_sync_initiator_rd_wait.sv | 28 ++
 rtl/ctl_sync_initiator.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ctl_sync_initiator_pkg.sv
// ctl_sync_initiator_pkg: control-BRAM address map shared with the FPGA-side
// controller, plus the state type of the bus-side sync initiator.
package ctl_sync_initiator_pkg;

  // Control BRAM word addresses (bit 9 of the bus address is 0 for this BRAM)
  localparam logic [8:0] ADDR_CTL_REG        = 9'h000;
  localparam logic [8:0] ADDR_EC_SYNC_TIME_0 = 9'h010;
  localparam logic [8:0] ADDR_EC_SYNC_TIME_1 = 9'h011;
  localparam logic [8:0] ADDR_EC_SYNC_TIME_2 = 9'h012;
  localparam logic [8:0] ADDR_EC_SYNC_TIME_3 = 9'h013;
  localparam logic [8:0] ADDR_CYCLE_BASE     = 9'h100;

  // Control register bit the initiator sets and the controller clears
  localparam int CTL_REG_SYNC_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_TIME,
    ST_WR_CYCLE,
    ST_RD_CTL,
    ST_WR_CTL,
    ST_POLL_GAP_W,
    ST_POLL_RD
  } ctl_sync_state_e;

  // Address of the 16-bit sync-time word 'word' (0 = least significant)
  function automatic logic [8:0] sync_time_addr(input logic [1:0] word);
    logic [8:0] addr;
    case (word)
      2'd0:    addr = ADDR_EC_SYNC_TIME_0;
      2'd1:    addr = ADDR_EC_SYNC_TIME_1;
      2'd2:    addr = ADDR_EC_SYNC_TIME_2;
      default: addr = ADDR_EC_SYNC_TIME_3;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/ctl_sync_initiator_rd_wait.sv
// ctl_bus_rd_wait: tracks an issued BRAM read through the read pipeline and
// strobes 'valid' in the cycle the read data is present on the bus.
module ctl_bus_rd_wait #(
  parameter int READ_LATENCY = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic issue,
  output logic valid
);

  logic [READ_LATENCY-1:0] pipe;

  // Shift the read-issued marker along one stage per cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe <= '0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign valid = pipe[READ_LATENCY-1];

endmodule

// File: rtl/ctl_sync_initiator.sv
// ctl_sync_initiator: bus-side initiator of the control-BRAM sync handshake.
// Writes the 64-bit sync time and the CYCLE table, sets the SYNC bit of the
// control register by read-modify-write, then polls until the controller
// clears it. Optional poll timeout is built in with CTL_SYNC_TIMEOUT_EN.
module ctl_sync_initiator
  import ctl_sync_initiator_pkg::*;
#(
  parameter int WIDTH          = 13,
  parameter int DEPTH          = 249,
  parameter int READ_LATENCY   = 2,
  parameter int POLL_GAP       = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [63:0]      SYNC_TIME,
  input  logic [WIDTH-1:0] CYCLE [0:DEPTH-1],
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic             BUS_EN,
  output logic             BUS_WE,
  output logic [9:0]       BUS_ADDR,
  output logic [15:0]      BUS_DATA_OUT,
  input  logic [15:0]      BUS_DATA_IN
);

  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0]  LAST_IDX  = 8'(DEPTH - 1);
  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [15:0] SYNC_MASK = 16'h0001 << CTL_REG_SYNC_BIT;

  ctl_sync_state_e state, next_state;
  logic [7:0]      idx, next_idx;
  logic [15:0]     gap_cnt, next_gap_cnt;
  logic [63:0]     sync_time_q;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            accept;
  logic            rd_issue, rd_valid;
  logic            tmo_hit;

  logic            bus_en_d, bus_we_d;
  logic [8:0]      bus_addr_d;
  logic [15:0]     bus_data_d;
  logic [63:0]     time_src;
  logic [5:0]      word_base;
  logic [IW-1:0]   cyc_sel;
  logic [15:0]     cycle_word;

  // A new request is taken only in IDLE and not in the DONE/ERR pulse cycle
  assign accept = (state == ST_IDLE) && START && !done_q && !err_q;

  // A read is outstanding from the cycle its request is on the bus
  assign rd_issue = BUS_EN && !BUS_WE;

  ctl_bus_rd_wait #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_wait (
    .CLK  (CLK),
    .RST  (RST),
    .issue(rd_issue),
    .valid(rd_valid)
  );

`ifdef CTL_SYNC_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt;
  logic        in_poll;

  assign in_poll = (state == ST_POLL_GAP_W) || (state == ST_POLL_RD);

  // Poll budget: cleared while writing the control register, counts poll phase
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt <= '0;
    end else if (state == ST_WR_CTL) begin
      tmo_cnt <= '0;
    end else if (in_poll) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_hit = in_poll && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // State register and handshake bookkeeping
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      sync_time_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state   <= next_state;
      idx     <= next_idx;
      gap_cnt <= next_gap_cnt;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        sync_time_q <= SYNC_TIME;
      end
    end
  end

  // Next-state logic; a successful poll sample wins over a same-cycle timeout
  always_comb begin
    next_state   = state;
    next_idx     = idx;
    next_gap_cnt = gap_cnt;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = ST_WR_TIME;
          next_idx   = '0;
        end
      end
      ST_WR_TIME: begin
        if (idx == 8'd3) begin
          next_state = ST_WR_CYCLE;
          next_idx   = '0;
        end else begin
          next_idx = idx + 8'd1;
        end
      end
      ST_WR_CYCLE: begin
        if (idx == LAST_IDX) begin
          next_state = ST_RD_CTL;
        end else begin
          next_idx = idx + 8'd1;
        end
      end
      ST_RD_CTL: begin
        if (rd_valid) begin
          next_state = ST_WR_CTL;
        end
      end
      ST_WR_CTL: begin
        next_state   = ST_POLL_GAP_W;
        next_gap_cnt = '0;
      end
      ST_POLL_GAP_W: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = ST_POLL_RD;
        end else begin
          next_gap_cnt = gap_cnt + 16'd1;
        end
      end
      ST_POLL_RD: begin
        if (rd_valid) begin
          if (!BUS_DATA_IN[CTL_REG_SYNC_BIT]) begin
            next_state = ST_IDLE;
            done_d     = 1'b1;
          end else begin
            next_state   = ST_POLL_GAP_W;
            next_gap_cnt = '0;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (tmo_hit && !done_d) begin
      next_state = ST_IDLE;
      err_d      = 1'b1;
    end
  end

  // Bus access for the coming cycle, decoded from the state being entered
  always_comb begin
    bus_en_d   = 1'b0;
    bus_we_d   = 1'b0;
    bus_addr_d = '0;
    bus_data_d = '0;
    time_src   = (state == ST_IDLE) ? SYNC_TIME : sync_time_q;
    word_base  = {next_idx[1:0], 4'b0000};
    cyc_sel    = next_idx[IW-1:0];
    cycle_word = '0;
    cycle_word[WIDTH-1:0] = CYCLE[cyc_sel];
    case (next_state)
      ST_WR_TIME: begin
        bus_en_d   = 1'b1;
        bus_we_d   = 1'b1;
        bus_addr_d = sync_time_addr(next_idx[1:0]);
        bus_data_d = time_src[word_base +: 16];
      end
      ST_WR_CYCLE: begin
        bus_en_d   = 1'b1;
        bus_we_d   = 1'b1;
        bus_addr_d = ADDR_CYCLE_BASE + {1'b0, next_idx};
        bus_data_d = cycle_word;
      end
      ST_RD_CTL: begin
        if (state != ST_RD_CTL) begin
          bus_en_d   = 1'b1;
          bus_addr_d = ADDR_CTL_REG;
        end
      end
      ST_WR_CTL: begin
        bus_en_d   = 1'b1;
        bus_we_d   = 1'b1;
        bus_addr_d = ADDR_CTL_REG;
        bus_data_d = BUS_DATA_IN | SYNC_MASK;
      end
      ST_POLL_RD: begin
        if (state != ST_POLL_RD) begin
          bus_en_d   = 1'b1;
          bus_addr_d = ADDR_CTL_REG;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered BRAM port
  always_ff @(posedge CLK) begin
    if (RST) begin
      BUS_EN       <= 1'b0;
      BUS_WE       <= 1'b0;
      BUS_ADDR     <= '0;
      BUS_DATA_OUT <= '0;
    end else begin
      BUS_EN       <= bus_en_d;
      BUS_WE       <= bus_we_d;
      BUS_ADDR     <= {1'b0, bus_addr_d};
      BUS_DATA_OUT <= bus_data_d;
    end
  end

  assign BUSY = (state != ST_IDLE) || done_q || err_q;
  assign DONE = done_q;

`ifdef CTL_SYNC_TIMEOUT_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule
